// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: issues one fetch per PC,
// hands the returned word to decode, then steps or redirects the PC.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  input  logic [31:0] PCPlus4,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JR,
  input  logic [31:0] JRTarget,
  input  logic        Flush,
  output logic [31:0] InstrCount
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_VALID = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   count_q, count_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   next_pc_c;
  logic [JIDX_W-1:0] jump_idx_c;
  logic              unused_bits_c;

  // Targets are word-aligned; their low two bits carry no information.
  assign unused_bits_c = ^{JRTarget[1:0], BranchTarget[1:0]};
  assign jump_idx_c    = JumpIndex;

  // Redirect selection for the instruction being accepted.
  always_comb begin
    next_pc_c = PCPlus4;
    if (JR) begin
      next_pc_c = {JRTarget[XLEN-1:2], 2'b00};
    end else if (Jump) begin
      next_pc_c = {PCPlus4[XLEN-1:XLEN-4], jump_idx_c, 2'b00};
    end else if (Branch) begin
      next_pc_c = {BranchTarget[XLEN-1:2], 2'b00};
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (Flush) pc_d = EXC_PC;
      end
      S_FETCH: begin
        if (ImemAck) begin
          if (Flush) begin
            pc_d = EXC_PC;
          end else begin
            instr_d = ImemRdata;
            state_d = S_VALID;
          end
        end else if (Flush) begin
          state_d = S_DRAIN;
        end
      end
      // The outstanding request must complete before the redirect is issued.
      S_DRAIN: begin
        if (ImemAck) begin
          pc_d    = EXC_PC;
          state_d = S_FETCH;
        end
      end
      S_VALID: begin
        if (Flush) begin
          pc_d    = EXC_PC;
          state_d = S_FETCH;
        end else if (InstrReady) begin
          pc_d    = next_pc_c;
          count_d = count_q + XLEN'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
    req_d   = (state_d == S_FETCH) || (state_d == S_DRAIN);
    valid_d = (state_d == S_VALID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

  assign PC         = pc_q;
  assign ImemAddr   = pc_q;
  assign ImemReq    = req_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign InstrCount = count_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the 32-bit CPU.
- Holds PC and drives it to the PC+4 adder and the instruction memory. Takes PCPlus4 back from the adder.
- Selects the next PC from sequential, branch, jump, jump-register or exception sources. Hands fetched instructions to decode over a valid/ready handshake.

Parameters:
RESET_PC  32'h00003000  PC value loaded on reset
EXC_PC    32'h00004180  PC value loaded on Flush (exception entry)

Ports:
clk         input   1   clock; all state updates on rising edge
rst_n       input   1   asynchronous, active-low reset
PC          output  32  current fetch address; feeds PC+4 adder
PCPlus4     input   32  PC+4 returned from adder
ImemReq     output  1   instruction memory request
ImemAddr    output  32  request address; always equals PC
ImemAck     input   1   one-cycle acknowledge; ImemRdata valid this cycle
ImemRdata   input   32  instruction word
Instr       output  32  fetched instruction presented to decode
InstrValid  output  1   Instr is valid
InstrReady  input   1   decode accepts Instr
Branch      input   1   taken branch for the instruction being accepted
BranchTarget input  32  branch target
Jump        input   1   j/jal for the instruction being accepted
JumpIndex   input   26  jump instruction index field
JR          input   1   jr/jalr for the instruction being accepted
JRTarget    input   32  register jump target
Flush       input   1   exception redirect to EXC_PC
InstrCount  output  32  number of accepted instructions

Behaviour:
- Reset (rst_n low, asynchronous):
  - PC=RESET_PC, Instr=0, InstrCount=0, state=BOOT.
  - All handshake outputs are 0: ImemReq=0, InstrValid=0.
- Mid-operation reset: takes effect immediately. Any in-flight request is abandoned, and a late ImemAck is ignored because ImemReq=0.
- Output decode:
  - ImemReq=1 only in FETCH and DRAIN.
  - InstrValid=1 only in VALID.
  - ImemAddr=PC always.
- State BOOT: next edge goes to FETCH. If Flush is high, PC<=EXC_PC.
- State FETCH:
  - ImemReq held high; PC held stable until ImemAck.
  - ImemAck & !Flush: Instr<=ImemRdata, go VALID.
  - ImemAck & Flush: data discarded, PC<=EXC_PC, stay FETCH.
  - !ImemAck & Flush: go DRAIN; PC is unchanged while the request is outstanding.
- State DRAIN:
  - ImemReq stays high at the old PC.
  - On ImemAck: data discarded, PC<=EXC_PC, go FETCH.
  - Flush is ignored in DRAIN.
- State VALID:
  - Instr held stable while InstrReady is low.
  - Flush has priority: PC<=EXC_PC, go FETCH, InstrCount unchanged.
  - Otherwise InstrReady high = accept: PC<=next PC, InstrCount<=InstrCount+1 (wraps 0xFFFFFFFF->0), go FETCH.
- Next-PC priority (sampled only on accept): JR > Jump > Branch > sequential.
  - JR: {JRTarget[31:2],2'b00}
  - Jump: {PCPlus4[31:28],JumpIndex,2'b00}
  - Branch: {BranchTarget[31:2],2'b00}
  - Sequential: PCPlus4
  - Redirect inputs are ignored outside accept.
- Arithmetic: PC addition is modulo 2^32; PC=0xFFFFFFFC sequential next is 0x00000000. PC[1:0] is always 00.
- Latency:
  - A zero-wait memory (ImemAck in the first FETCH cycle) gives InstrValid on the following cycle.
  - Maximum throughput is one instruction per 2 cycles.
  - First ImemReq is asserted one cycle after reset release.

Test Plan:
- Reset release, memory acks every request with zero wait, InstrReady=1 -> ImemAddr sequence 0x3000, 0x3004, 0x3008. InstrValid pulses every 2nd cycle; InstrCount=3 after the third accept.
- InstrReady low for 5 cycles in VALID -> Instr and PC stable, ImemReq=0, InstrCount unchanged. Accept on the 6th cycle -> next address 0x3004.
- Accept at PC=0x3010 with Jump=1, JumpIndex=0x0000100 and Branch=1, BranchTarget=0x5000 -> next ImemAddr=0x00000400 (jump wins over branch). Same accept with JR=1, JRTarget=0x6003 -> 0x6000.
- Flush during FETCH with ack delayed 3 cycles -> DRAIN holds ImemAddr at the old PC. The ack data never appears on Instr; the next request is at 0x4180.
- PC forced to 0xFFFFFFFC (via JR), sequential accept -> next ImemAddr=0x00000000. InstrCount at 0xFFFFFFFF wraps to 0 on accept.
- rst_n asserted low while in DRAIN -> outputs return to reset values immediately; the pending ImemAck is ignored and fetch restarts at 0x3000.
